// File: rtl/csa_stream_accumulator.sv
// Carry-save stream accumulator: one operand per cycle in redundant form, then a
// chunked carry-propagate resolve and a valid/ready result hold.
module csa_stream_accumulator #(
  parameter int WIDTH = 48,
  parameter int GUARD = 4,
  parameter int CHUNK = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH+GUARD-1:0]   out_data,
  output logic                     out_ovf,
  output logic                     busy
);

  localparam int ACC_W  = WIDTH + GUARD;
  localparam int NCHUNK = (ACC_W + CHUNK - 1) / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {ACC, RESOLVE, HOLD} state_t;

  state_t             state_reg;
  logic [ACC_W-1:0]   s_reg;
  logic [ACC_W-1:0]   c_reg;
  logic               ovf_reg;
  logic               cpa_c_reg;
  logic [IDX_W-1:0]   idx_reg;
  logic [ACC_W-1:0]   x;
  logic [ACC_W-1:0]   maj;
  logic [NCHUNK-1:0]  chunk_cout;
  logic               res_en;

  assign x      = ACC_W'(in_data);
  assign maj    = (s_reg & c_reg) | (s_reg & x) | (c_reg & x);
  assign res_en = (state_reg == RESOLVE) && !clr;

  assign in_ready  = (state_reg == ACC);
  assign out_valid = (state_reg == HOLD);
  assign busy      = (state_reg != ACC);
  assign out_ovf   = ovf_reg;

  // One adder per chunk; only the chunk selected by idx_reg is captured each cycle.
  // The top chunk may be narrower, so its carry out lands exactly at bit ACC_W.
  for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_chunk
    localparam int LO = gi * CHUNK;
    localparam int W  = (LO + CHUNK > ACC_W) ? (ACC_W - LO) : CHUNK;
    localparam int W1 = W + 1;
    logic [W:0]   csum;
    logic [W-1:0] res_reg;

    assign csum = {1'b0, s_reg[LO +: W]} + {1'b0, c_reg[LO +: W]} + W1'(cpa_c_reg);
    assign chunk_cout[gi] = csum[W];
    assign out_data[LO +: W] = res_reg;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        res_reg <= '0;
      end else if (res_en && idx_reg == IDX_W'(gi)) begin
        res_reg <= csum[W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ACC;
      s_reg     <= '0;
      c_reg     <= '0;
      ovf_reg   <= 1'b0;
      cpa_c_reg <= 1'b0;
      idx_reg   <= '0;
    end else if (clr) begin
      state_reg <= ACC;
      s_reg     <= '0;
      c_reg     <= '0;
      ovf_reg   <= 1'b0;
      cpa_c_reg <= 1'b0;
      idx_reg   <= '0;
    end else begin
      case (state_reg)
        ACC: begin
          if (in_valid) begin
            s_reg   <= s_reg ^ c_reg ^ x;
            c_reg   <= {maj[ACC_W-2:0], 1'b0};
            // The carry shifted out of the top bit is a weight-2^ACC_W overflow.
            ovf_reg <= ovf_reg | maj[ACC_W-1];
            if (in_last) begin
              state_reg <= RESOLVE;
              idx_reg   <= '0;
              cpa_c_reg <= 1'b0;
            end
          end
        end
        RESOLVE: begin
          cpa_c_reg <= chunk_cout[idx_reg];
          if (idx_reg == IDX_W'(NCHUNK - 1)) begin
            ovf_reg   <= ovf_reg | chunk_cout[idx_reg];
            state_reg <= HOLD;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            s_reg     <= '0;
            c_reg     <= '0;
            ovf_reg   <= 1'b0;
            state_reg <= ACC;
          end
        end
        default: state_reg <= ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_stream_accumulator.sv
// Scoreboard bench for csa_stream_accumulator: expected {ovf,sum} is queued when a
// group is driven and compared when the result handshake completes.
module tb_csa_stream_accumulator;

  localparam int WIDTH = 48;
  localparam int ACC_W = 52;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              clr = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [WIDTH-1:0]  in_data = '0;
  logic              in_last = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [ACC_W-1:0]  out_data;
  logic              out_ovf;
  logic              busy;

  int checks = 0;
  int failures = 0;
  logic [ACC_W:0] exp_q[$];
  logic [WIDTH-1:0] ops[64];

  csa_stream_accumulator #(.WIDTH(48), .GUARD(4), .CHUNK(16)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one beat, optionally after random idle cycles (with stray in_last noise).
  task automatic drive_beat(input logic [WIDTH-1:0] d, input logic last, input bit gaps);
    int n = 0;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        in_last  = 1'($urandom_range(0, 1));
        step();
      end
      in_last = 1'b0;
    end
    while (!in_ready && n < 100) begin
      step();
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Wait for the result, optionally stall, then pop the scoreboard and compare.
  task automatic collect(input string tag, input int stall);
    int lat = 0;
    logic [ACC_W:0] e;
    out_ready = 1'b0;
    while (!out_valid && lat < 200) begin
      step();
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'd4);
    chk({tag, "_qsize"}, 64'(exp_q.size()), 64'd1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    for (int i = 0; i < stall; i++) begin
      chk({tag, "_hold_data"}, 64'(out_data), 64'(e[ACC_W-1:0]));
      chk({tag, "_hold_in_ready"}, 64'(in_ready), 64'd0);
      chk({tag, "_hold_busy"}, 64'(busy), 64'd1);
      step();
    end
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_data"}, 64'(out_data), 64'(e[ACC_W-1:0]));
    chk({tag, "_ovf"}, 64'(out_ovf), 64'(e[ACC_W]));
    $display("group %s: data=0x%0h ovf=%0d exp_data=0x%0h exp_ovf=%0d",
             tag, out_data, out_ovf, e[ACC_W-1:0], e[ACC_W]);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_post_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_post_in_ready"}, 64'(in_ready), 64'd1);
  endtask

  // Reference: plain wide sum of ops[0..n-1].
  task automatic run_group(input string tag, input int n, input bit gaps, input int stall);
    logic [63:0] sum = '0;
    for (int i = 0; i < n; i++) sum += 64'(ops[i]);
    exp_q.push_back({|sum[63:ACC_W], sum[ACC_W-1:0]});
    for (int i = 0; i < n; i++) drive_beat(ops[i], (i == n - 1), gaps);
    collect(tag, stall);
  endtask

  initial begin
    #12;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_ovf", 64'(out_ovf), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    step();

    ops[0] = 48'h5;
    run_group("single5", 1, 1'b0, 0);

    ops[0] = 48'hFFFF_FFFF_FFFF; ops[1] = 48'h1; ops[2] = 48'h10;
    run_group("three", 3, 1'b0, 0);

    for (int i = 0; i < 17; i++) ops[i] = '1;
    run_group("ones17", 17, 1'b0, 0);
    run_group("ones16", 16, 1'b0, 0);

    ops[0] = 48'h1234_5678_9ABC; ops[1] = 48'hFEDC_BA98_7654;
    run_group("stall5", 2, 1'b0, 5);

    // Abort a partial group; the beat presented alongside clr must be dropped.
    drive_beat(48'h111, 1'b0, 1'b0);
    drive_beat(48'h222, 1'b0, 1'b0);
    drive_beat(48'h333, 1'b0, 1'b0);
    clr = 1'b1; in_valid = 1'b1; in_data = 48'h444; in_last = 1'b1;
    step();
    clr = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    chk("clr_in_ready", 64'(in_ready), 64'd1);
    chk("clr_busy", 64'(busy), 64'd0);
    ops[0] = 48'h7;
    run_group("after_clr", 1, 1'b0, 0);

    // Asynchronous reset in the middle of RESOLVE.
    drive_beat(48'h9, 1'b1, 1'b0);
    step();
    step();
    chk("mid_resolve_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    chk("arst_out_data", 64'(out_data), 64'd0);
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_out_ovf", 64'(out_ovf), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    step();
    ops[0] = 48'h2;
    run_group("after_rst", 1, 1'b0, 0);

    for (int g = 0; g < 30; g++) begin
      int n = $urandom_range(1, 40);
      int mode = $urandom_range(0, 2);
      for (int i = 0; i < n; i++) begin
        logic [63:0] r = {$urandom, $urandom};
        ops[i] = (mode == 0) ? '1 : (mode == 1) ? {1'b1, r[46:0]} : r[47:0];
      end
      run_group($sformatf("rand%0d", g), n, 1'b1, $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
